// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way, WIDTH-bit channel selector whose result is captured in a
// registered output stage with a two-entry skid buffer under valid/ready.
// Out-of-range selects pass zero data through and are flagged in a sticky bit
// and a saturating 8-bit counter.
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err,
    output logic [7:0]           err_cnt
);

    // Channel count widened by one bit so sel >= N can be compared without
    // truncation, even when N is an exact power of two.
    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    // Occupancy of the two-entry output stage.
    //   ST_EMPTY : main entry invalid
    //   ST_ONE   : main entry valid, skid entry invalid
    //   ST_FULL  : both entries valid, upstream is stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Main entry drives the outputs; skid entry absorbs one transfer while the
    // downstream stalls so that in_ready never depends on out_ready.
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;
    logic [SEL_W-1:0] main_sel_q;
    logic [SEL_W-1:0] main_sel_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;
    logic [SEL_W-1:0] skid_sel_q;
    logic [SEL_W-1:0] skid_sel_d;

    logic             sel_err_q;
    logic             sel_err_d;
    logic [7:0]       err_cnt_q;
    logic [7:0]       err_cnt_d;

    logic [WIDTH-1:0] cap_data_s;
    logic             sel_oor_s;
    logic             accept_s;
    logic             take_s;
    logic             load_main_new_s;
    logic             load_main_skid_s;
    logic             load_skid_s;

    // Selected channel value; an out-of-range select matches no channel and
    // therefore yields zero.
    always_comb begin
        cap_data_s = '0;
        for (int k = 0; k < N; k++) begin
            cap_data_s = cap_data_s
                       | ({WIDTH{sel == SEL_W'(k)}} & in_data[k*WIDTH +: WIDTH]);
        end
    end

    // Handshake qualification: a flushed accept is discarded entirely.
    always_comb begin
        sel_oor_s = ({1'b0, sel} >= N_EXT);
        accept_s  = in_valid && in_ready;
        take_s    = accept_s && !flush;
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and entry load strobes; flush overrides everything.
    always_comb begin
        state_d          = state_q;
        load_main_new_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d         = ST_ONE;
                        load_main_new_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && out_ready) begin
                        state_d         = ST_ONE;
                        load_main_new_s = 1'b1;
                    end else if (accept_s) begin
                        state_d     = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_d          = ST_ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decoded purely from the registered occupancy.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL);
    end

    // Next values of the main and skid entries.
    always_comb begin
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        if (load_main_new_s) begin
            main_data_d = cap_data_s;
            main_sel_d  = sel;
        end else if (load_main_skid_s) begin
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
        end else begin
            main_data_d = main_data_q;
            main_sel_d  = main_sel_q;
        end
        if (load_skid_s) begin
            skid_data_d = cap_data_s;
            skid_sel_d  = sel;
        end else begin
            skid_data_d = skid_data_q;
            skid_sel_d  = skid_sel_q;
        end
    end

    // Error bookkeeping: only accepts that really enter the stage count, and
    // neither the flag nor the counter is cleared by flush.
    always_comb begin
        sel_err_d = sel_err_q;
        err_cnt_d = err_cnt_q;
        if (take_s && sel_oor_s) begin
            sel_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            sel_err_d = sel_err_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // Entry and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            sel_err_q   <= sel_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_data = main_data_q;
    assign out_sel  = main_sel_q;
    assign sel_err  = sel_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: four instances (N=4/W=32, N=3/W=32, N=2/W=5,
// N=16/W=64). The N=4 instance is tracked by a queue model of the FIFO.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A: N=4, WIDTH=32 ----------------
    logic         rst_a;
    logic [127:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;
    logic [7:0]   a_err_cnt;
    logic [31:0]  a_chan [4];

    mux_n_pipe #(.WIDTH(32), .N(4)) dut_a (
        .clk(clk), .rst(rst_a), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
        .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sel_err(a_sel_err), .err_cnt(a_err_cnt));

    // ---------------- instance B: N=3, WIDTH=32 ----------------
    logic         rst_b;
    logic [95:0]  b_in_data;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [31:0]  b_out_data;
    logic [1:0]   b_out_sel;
    logic [7:0]   b_err_cnt;
    logic [31:0]  b_chan [3];

    mux_n_pipe #(.WIDTH(32), .N(3)) dut_b (
        .clk(clk), .rst(rst_b), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
        .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel_err(b_sel_err), .err_cnt(b_err_cnt));

    // ---------------- instance C: N=2, WIDTH=5 ----------------
    logic         c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_sel_err;
    logic [9:0]   c_in_data;
    logic [0:0]   c_sel;
    logic [4:0]   c_out_data;
    logic [0:0]   c_out_sel;
    logic [7:0]   c_err_cnt;
    logic [4:0]   c_chan [2];

    mux_n_pipe #(.WIDTH(5), .N(2)) dut_c (
        .clk(clk), .rst(rst_a), .in_data(c_in_data), .sel(c_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .flush(c_flush),
        .out_data(c_out_data), .out_sel(c_out_sel), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .sel_err(c_sel_err), .err_cnt(c_err_cnt));

    // ---------------- instance D: N=16, WIDTH=64 ----------------
    logic          d_in_valid, d_in_ready, d_flush, d_out_valid, d_out_ready, d_sel_err;
    logic [1023:0] d_in_data;
    logic [3:0]    d_sel;
    logic [63:0]   d_out_data;
    logic [3:0]    d_out_sel;
    logic [7:0]    d_err_cnt;
    logic [63:0]   d_chan [16];

    mux_n_pipe #(.WIDTH(64), .N(16)) dut_d (
        .clk(clk), .rst(rst_a), .in_data(d_in_data), .sel(d_sel),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .flush(d_flush),
        .out_data(d_out_data), .out_sel(d_out_sel), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .sel_err(d_sel_err), .err_cnt(d_err_cnt));

    // ---------------- reference model for A: a FIFO of capacity 2 ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } ent_t;
    ent_t qa[$];

    task automatic pack_a();
        a_in_data = {a_chan[3], a_chan[2], a_chan[1], a_chan[0]};
    endtask

    task automatic pack_b();
        b_in_data = {b_chan[2], b_chan[1], b_chan[0]};
    endtask

    // One clock of instance A: compare against the model, then advance both.
    task automatic step_a(input string tag);
        logic acc;
        logic pop;
        ent_t e;
        n_checks++;
        if (a_out_valid !== (qa.size() > 0)) begin
            n_errors++;
            $display("FAIL %s out_valid: got %0b want %0b", tag, a_out_valid, qa.size() > 0);
        end
        n_checks++;
        if (a_in_ready !== (qa.size() < 2)) begin
            n_errors++;
            $display("FAIL %s in_ready: got %0b want %0b", tag, a_in_ready, qa.size() < 2);
        end
        if (qa.size() > 0) begin
            n_checks++;
            if (a_out_data !== qa[0].d || a_out_sel !== qa[0].s) begin
                n_errors++;
                $display("FAIL %s out_data/out_sel: got %h/%0d want %h/%0d",
                         tag, a_out_data, a_out_sel, qa[0].d, qa[0].s);
            end
        end
        acc = a_in_valid && (qa.size() < 2);
        pop = (qa.size() > 0) && a_out_ready;
        e.d = a_chan[a_sel];
        e.s = a_sel;
        @(posedge clk);
        if (a_flush) begin
            qa.delete();
        end else begin
            if (pop) void'(qa.pop_front());
            if (acc) qa.push_back(e);
        end
        #1;
    endtask

    task automatic drain_a();
        a_in_valid  = 1'b0;
        a_flush     = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step_a("drain");
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_sel !== 2'd0 ||
            a_in_ready !== 1'b1 || a_sel_err !== 1'b0 || a_err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_a: got v=%0b d=%h s=%0d r=%0b e=%0b c=%0d want 0 0 0 1 0 0",
                     a_out_valid, a_out_data, a_out_sel, a_in_ready, a_sel_err, a_err_cnt);
        end
        n_checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_sel_err !== 1'b0 || b_err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_b: got v=%0b r=%0b e=%0b c=%0d want 0 1 0 0",
                     b_out_valid, b_in_ready, b_sel_err, b_err_cnt);
        end
        n_checks++;
        if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_cd: got c v=%0b r=%0b d v=%0b r=%0b want 0 1 0 1",
                     c_out_valid, c_in_ready, d_out_valid, d_in_ready);
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_d [4];
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        a_chan = '{32'h11, 32'h22, 32'h33, 32'h44};
        pack_a();
        a_out_ready = 1'b1;
        a_flush     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_sel      = 2'(i);
            a_in_valid = 1'b1;
            step_a("stream");
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[i] || a_out_sel !== 2'(i)) begin
                n_errors++;
                $display("FAIL stream_%0d: got v=%0b d=%h s=%0d want 1 %h %0d",
                         i, a_out_valid, a_out_data, a_out_sel, exp_d[i], i);
            end
        end
        drain_a();
    endtask

    task automatic test_back_pressure();
        a_chan = '{32'h11, 32'h22, 32'h33, 32'h44};
        pack_a();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_sel = 2'd2;
        step_a("bp_fill");
        a_sel = 2'd3;
        step_a("bp_fill");
        n_checks++;
        if (a_in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_in_ready_low: got %0b want 0", a_in_ready);
        end
        a_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step_a("bp_stall");
            n_checks++;
            if (a_in_ready !== 1'b0 || a_out_data !== 32'h33) begin
                n_errors++;
                $display("FAIL bp_stall: got r=%0b d=%h want 0 00000033", a_in_ready, a_out_data);
            end
        end
        a_out_ready = 1'b1;
        step_a("bp_release");
        n_checks++;
        if (a_out_data !== 32'h44 || a_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_second: got d=%h r=%0b want 00000044 1", a_out_data, a_in_ready);
        end
        step_a("bp_release");
        n_checks++;
        if (a_out_data !== 32'h11 || a_out_sel !== 2'd0 || a_out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_third: got d=%h s=%0d v=%0b want 00000011 0 1",
                     a_out_data, a_out_sel, a_out_valid);
        end
        drain_a();
    endtask

    task automatic test_flush();
        a_chan = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        pack_a();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_sel = 2'd0;
        step_a("flush_fill");
        a_sel = 2'd1;
        step_a("flush_fill");
        a_flush = 1'b1;
        a_sel   = 2'd2;
        step_a("flush_full");
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_full_after: got v=%0b r=%0b want 0 1", a_out_valid, a_in_ready);
        end
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step_a("flush_quiet");
        a_in_valid = 1'b1;
        a_sel = 2'd3;
        step_a("flush_one");
        a_flush = 1'b1;
        a_sel   = 2'd2;
        step_a("flush_one");
        a_flush = 1'b0;
        drain_a();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) a_chan[k] = $urandom;
            pack_a();
            a_sel       = 2'($urandom_range(0, 3));
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 31) == 0);
            step_a("random");
        end
        drain_a();
    endtask

    task automatic test_out_of_range();
        int exp_cnt;
        for (int k = 0; k < 3; k++) b_chan[k] = $urandom | 32'h1;
        pack_b();
        b_flush     = 1'b0;
        b_out_ready = 1'b1;
        b_sel       = 2'd3;
        b_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h0 || b_out_sel !== 2'd3 ||
            b_sel_err !== 1'b1 || b_err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL oor_first: got v=%0b d=%h s=%0d e=%0b c=%0d want 1 0 3 1 1",
                     b_out_valid, b_out_data, b_out_sel, b_sel_err, b_err_cnt);
        end
        b_flush    = 1'b1;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        n_checks++;
        if (b_err_cnt !== 8'd1 || b_out_valid !== 1'b0 || b_sel_err !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_flush: got c=%0d v=%0b e=%0b want 1 0 1", b_err_cnt, b_out_valid, b_sel_err);
        end
        b_sel      = 2'd2;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        n_checks++;
        if (b_out_data !== b_chan[2] || b_out_sel !== 2'd2 || b_err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL oor_inrange: got d=%h s=%0d c=%0d want %h 2 1",
                     b_out_data, b_out_sel, b_err_cnt, b_chan[2]);
        end
        exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            b_sel      = 2'd3;
            b_in_valid = 1'b1;
            @(posedge clk);
            #1;
            exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
            n_checks++;
            if (b_err_cnt !== 8'(exp_cnt) || b_out_data !== 32'h0) begin
                n_errors++;
                $display("FAIL oor_sat_%0d: got c=%0d d=%h want %0d 0", i, b_err_cnt, b_out_data, exp_cnt);
            end
        end
        b_in_valid = 1'b0;
        n_checks++;
        if (b_err_cnt !== 8'd255 || b_sel_err !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_sat_final: got c=%0d e=%0b want 255 1", b_err_cnt, b_sel_err);
        end
    endtask

    task automatic test_async_reset();
        rst_b = 1'b1;
        #1;
        rst_b = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_sel      = 2'd3;
            b_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        b_out_ready = 1'b0;
        b_sel       = 2'd0;
        @(posedge clk);
        #1;
        n_checks++;
        if (b_in_ready !== 1'b0 || b_err_cnt !== 8'd5) begin
            n_errors++;
            $display("FAIL arst_setup: got r=%0b c=%0d want 0 5", b_in_ready, b_err_cnt);
        end
        b_sel = 2'd2;
        @(negedge clk);
        #1;
        rst_b = 1'b1;
        #1;
        n_checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 32'h0 || b_out_sel !== 2'd0 ||
            b_in_ready !== 1'b1 || b_sel_err !== 1'b0 || b_err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL arst_clear: got v=%0b d=%h s=%0d r=%0b e=%0b c=%0d want 0 0 0 1 0 0",
                     b_out_valid, b_out_data, b_out_sel, b_in_ready, b_sel_err, b_err_cnt);
        end
        #1;
        rst_b = 1'b0;
        for (int k = 0; k < 3; k++) b_chan[k] = $urandom;
        pack_b();
        b_sel       = 2'd1;
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== b_chan[1] || b_out_sel !== 2'd1 || b_err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL arst_first: got v=%0b d=%h s=%0d c=%0d want 1 %h 1 0",
                     b_out_valid, b_out_data, b_out_sel, b_err_cnt, b_chan[1]);
        end
    endtask

    task automatic test_sweep_n2();
        c_out_ready = 1'b1;
        c_flush     = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 2; j++) begin
                    c_chan[j] = 5'($urandom);
                    c_in_data[j*5 +: 5] = c_chan[j];
                end
                c_sel      = 1'(k);
                c_in_valid = 1'b1;
                @(posedge clk);
                #1;
                n_checks++;
                if (c_out_valid !== 1'b1 || c_out_data !== c_chan[k] || c_out_sel !== 1'(k)) begin
                    n_errors++;
                    $display("FAIL sweep_n2_ch%0d: got v=%0b d=%h s=%0d want 1 %h %0d",
                             k, c_out_valid, c_out_data, c_out_sel, c_chan[k], k);
                end
            end
        end
        c_in_valid = 1'b0;
        n_checks++;
        if (c_sel_err !== 1'b0 || c_err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL sweep_n2_err: got e=%0b c=%0d want 0 0", c_sel_err, c_err_cnt);
        end
    endtask

    task automatic test_sweep_n16();
        d_out_ready = 1'b1;
        d_flush     = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) begin
                d_chan[j] = {$urandom, $urandom};
                d_in_data[j*64 +: 64] = d_chan[j];
            end
            d_sel      = 4'(k);
            d_in_valid = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (d_out_valid !== 1'b1 || d_out_data !== d_chan[k] || d_out_sel !== 4'(k)) begin
                n_errors++;
                $display("FAIL sweep_n16_ch%0d: got v=%0b d=%h s=%0d want 1 %h %0d",
                         k, d_out_valid, d_out_data, d_out_sel, d_chan[k], k);
            end
        end
        d_in_valid = 1'b0;
        n_checks++;
        if (d_sel_err !== 1'b0 || d_err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL sweep_n16_err: got e=%0b c=%0d want 0 0", d_sel_err, d_err_cnt);
        end
    endtask

    initial begin
        a_in_data = '0; a_sel = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_sel = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        c_in_data = '0; c_sel = '0; c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b0;
        d_in_data = '0; d_sel = '0; d_in_valid = 1'b0; d_flush = 1'b0; d_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) a_chan[k] = '0;
        for (int k = 0; k < 3; k++) b_chan[k] = '0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_random();
        test_out_of_range();
        test_async_reset();
        test_sweep_n2();
        test_sweep_n16();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
